// File: rtl/reg_fifo_drain_pkg.sv
// Shared register map, status-byte layout and stage FSM encodings for the capture-FIFO drain block.
package reg_fifo_drain_pkg;

    localparam logic [5:0] REG_FIFO_DATA   = 6'h30;
    localparam logic [5:0] REG_FIFO_STAT   = 6'h31;
    localparam logic [5:0] REG_CH_SEL      = 6'h32;
    localparam logic [5:0] REG_OVF         = 6'h33;
    localparam logic [5:0] REG_POP_CNT     = 6'h34;
    localparam logic [5:0] REG_FLUSH       = 6'h35;
    localparam logic [5:0] REG_POP_CNT_CLR = 6'h36;

    localparam int ST_VALID   = 0;
    localparam int ST_EMPTY   = 1;
    localparam int ST_UDF     = 2;
    localparam int ST_OVF     = 3;
    localparam int ST_TAG_LSB = 4;

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_FETCH  = 2'd1;
    localparam logic [1:0] S_WAIT   = 2'd2;
    localparam logic [1:0] S_LOADED = 2'd3;

    function automatic int ceil_div8(input int bits);
        return (bits + 7) / 8;
    endfunction

endpackage

// File: rtl/fifo_stage_fsm.sv
// Prefetch controller: pops one entry from the selected FIFO into a staging register and
// holds it until the register side consumes or flushes it.
module fifo_stage_fsm
    import reg_fifo_drain_pkg::*;
#(
    parameter int pENTRY_WIDTH = 18,
    parameter int pCHANNELS    = 2
) (
    input  logic                              i_clk,
    input  logic                              i_reset,
    input  logic [3:0]                        i_ch_sel,
    input  logic [pCHANNELS-1:0]              i_fifo_empty,
    input  logic [pCHANNELS*pENTRY_WIDTH-1:0] i_fifo_dout,
    input  logic                              i_flush,
    input  logic                              i_consume,
    output logic [pCHANNELS-1:0]              o_fifo_rd_en,
    output logic                              o_valid,
    output logic [3:0]                        o_tag,
    output logic [pENTRY_WIDTH-1:0]           o_data,
    output logic                              o_loaded,
    output logic                              o_drop_inflight
);

    logic [1:0]              r_state, w_state_d;
    logic [3:0]              r_tag, w_tag_d;
    logic                    r_valid, w_valid_d;
    logic [pENTRY_WIDTH-1:0] r_data, w_data_d;
    logic                    w_empty_sel;
    logic [pENTRY_WIDTH-1:0] w_dout_tag;

    always_comb begin
        w_empty_sel = 1'b1;
        w_dout_tag  = '0;
        for (int c = 0; c < pCHANNELS; c++) begin
            if (i_ch_sel == 4'(c)) w_empty_sel = i_fifo_empty[c];
            if (r_tag == 4'(c)) w_dout_tag = i_fifo_dout[c*pENTRY_WIDTH +: pENTRY_WIDTH];
        end
    end

    // Tag is captured on entry to FETCH so the pop and the later capture use the same channel.
    always_comb begin
        w_state_d = r_state;
        w_tag_d   = r_tag;
        w_valid_d = r_valid;
        w_data_d  = r_data;
        case (r_state)
            S_IDLE: begin
                if (!w_empty_sel) begin
                    w_state_d = S_FETCH;
                    w_tag_d   = i_ch_sel;
                end
            end
            S_FETCH: w_state_d = S_WAIT;
            S_WAIT: begin
                w_data_d  = w_dout_tag;
                w_valid_d = 1'b1;
                w_state_d = S_LOADED;
            end
            S_LOADED: begin
                if (i_consume) begin
                    w_valid_d = 1'b0;
                    w_state_d = S_IDLE;
                end
            end
            default: w_state_d = S_IDLE;
        endcase
        if (i_flush) begin
            w_valid_d = 1'b0;
            w_state_d = S_IDLE;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state <= S_IDLE;
            r_tag   <= '0;
            r_valid <= 1'b0;
            r_data  <= '0;
        end else begin
            r_state <= w_state_d;
            r_tag   <= w_tag_d;
            r_valid <= w_valid_d;
            r_data  <= w_data_d;
        end
    end

    always_comb begin
        o_fifo_rd_en = '0;
        for (int c = 0; c < pCHANNELS; c++) begin
            o_fifo_rd_en[c] = (r_state == S_FETCH) && (r_tag == 4'(c));
        end
    end

    assign o_valid         = r_valid;
    assign o_tag           = r_tag;
    assign o_data          = r_data;
    assign o_loaded        = (r_state == S_LOADED);
    assign o_drop_inflight = i_flush && ((r_state == S_FETCH) || (r_state == S_WAIT));

endmodule

// File: rtl/reg_fifo_drain.sv
// Register front end that drains the capture FIFOs byte-serially: decode, sticky flags,
// saturating pop counter and the registered read mux.
module reg_fifo_drain
    import reg_fifo_drain_pkg::*;
#(
    parameter int pENTRY_WIDTH = 18,
    parameter int pCHANNELS    = 2,
    parameter int pCNT_WIDTH   = 16
) (
    input  logic                              cwusb_clk,
    input  logic                              reset_i,
    input  logic [5:0]                        reg_address,
    input  logic [15:0]                       reg_bytecnt,
    input  logic                              reg_read,
    input  logic                              reg_write,
    input  logic                              reg_addrvalid,
    input  logic [7:0]                        write_data,
    output logic [7:0]                        read_data,
    output logic [pCHANNELS-1:0]              O_fifo_rd_en,
    input  logic [pCHANNELS*pENTRY_WIDTH-1:0] I_fifo_dout,
    input  logic [pCHANNELS-1:0]              I_fifo_empty,
    input  logic [pCHANNELS-1:0]              I_fifo_overflow
);

    localparam int pNBYTES    = ceil_div8(pENTRY_WIDTH);
    localparam int pOVF_BYTES = ceil_div8(pCHANNELS);
    localparam int pCNT_BYTES = pCNT_WIDTH / 8;

    logic [7:0]            r_read_data;
    logic [3:0]            r_ch_sel;
    logic                  r_udf;
    logic [pCHANNELS-1:0]  r_ovf;
    logic [pCNT_WIDTH-1:0] r_pop_cnt;

    logic                      w_acc, w_wr, w_consume, w_flush, w_cnt_clr, w_chsel_wr;
    logic                      w_udf_set, w_empty_cur, w_drop, w_valid, w_loaded;
    logic [3:0]                w_tag;
    logic [pENTRY_WIDTH-1:0]   w_data;
    logic [7:0]                w_status, w_rd_byte;
    logic [pNBYTES*8-1:0]      w_stage_pad;
    logic [pOVF_BYTES*8-1:0]   w_ovf_pad;

    assign w_acc      = reg_addrvalid & reg_read;
    assign w_wr       = reg_addrvalid & reg_write;
    assign w_flush    = w_wr && (reg_address == REG_FLUSH) && (reg_bytecnt == 16'd0);
    assign w_cnt_clr  = w_wr && (reg_address == REG_POP_CNT_CLR) && (reg_bytecnt == 16'd0);
    assign w_chsel_wr = w_wr && (reg_address == REG_CH_SEL) && (reg_bytecnt == 16'd0);
    assign w_consume  = w_acc && (reg_address == REG_FIFO_DATA)
                        && (reg_bytecnt == 16'(pNBYTES)) && w_loaded;
    assign w_udf_set  = w_acc && (reg_address == REG_FIFO_DATA)
                        && (reg_bytecnt == 16'd0) && !w_valid;

    fifo_stage_fsm #(
        .pENTRY_WIDTH (pENTRY_WIDTH),
        .pCHANNELS    (pCHANNELS)
    ) u_stage (
        .i_clk           (cwusb_clk),
        .i_reset         (reset_i),
        .i_ch_sel        (r_ch_sel),
        .i_fifo_empty    (I_fifo_empty),
        .i_fifo_dout     (I_fifo_dout),
        .i_flush         (w_flush),
        .i_consume       (w_consume),
        .o_fifo_rd_en    (O_fifo_rd_en),
        .o_valid         (w_valid),
        .o_tag           (w_tag),
        .o_data          (w_data),
        .o_loaded        (w_loaded),
        .o_drop_inflight (w_drop)
    );

    always_comb begin
        w_empty_cur = 1'b1;
        for (int c = 0; c < pCHANNELS; c++) begin
            if (r_ch_sel == 4'(c)) w_empty_cur = I_fifo_empty[c];
        end
        w_stage_pad                   = '0;
        w_stage_pad[pENTRY_WIDTH-1:0] = w_data;
        w_ovf_pad                     = '0;
        w_ovf_pad[pCHANNELS-1:0]      = r_ovf;
    end

    // The underflowing read itself already reports the underflow bit.
    always_comb begin
        w_status                 = '0;
        w_status[ST_VALID]       = w_valid;
        w_status[ST_EMPTY]       = w_empty_cur;
        w_status[ST_UDF]         = r_udf | w_udf_set;
        w_status[ST_OVF]         = |r_ovf;
        w_status[ST_TAG_LSB +: 4] = w_tag;
    end

    always_comb begin
        w_rd_byte = '0;
        if (w_acc) begin
            case (reg_address)
                REG_FIFO_DATA: begin
                    if (reg_bytecnt == 16'd0) w_rd_byte = w_status;
                    for (int k = 0; k < pNBYTES; k++) begin
                        if (reg_bytecnt == 16'(k + 1) && w_valid) w_rd_byte = w_stage_pad[k*8 +: 8];
                    end
                end
                REG_FIFO_STAT: begin
                    if (reg_bytecnt == 16'd0) w_rd_byte = w_status;
                end
                REG_CH_SEL: begin
                    if (reg_bytecnt == 16'd0) w_rd_byte = {4'b0, r_ch_sel};
                end
                REG_OVF: begin
                    for (int k = 0; k < pOVF_BYTES; k++) begin
                        if (reg_bytecnt == 16'(k)) w_rd_byte = w_ovf_pad[k*8 +: 8];
                    end
                end
                REG_POP_CNT: begin
                    for (int k = 0; k < pCNT_BYTES; k++) begin
                        if (reg_bytecnt == 16'(k)) w_rd_byte = r_pop_cnt[k*8 +: 8];
                    end
                end
                default: w_rd_byte = '0;
            endcase
        end
    end

    // Flushing an in-flight entry still counts: the FIFO was already popped.
    always_ff @(posedge cwusb_clk) begin
        if (reset_i) begin
            r_read_data <= '0;
            r_ch_sel    <= '0;
            r_udf       <= 1'b0;
            r_ovf       <= '0;
            r_pop_cnt   <= '0;
        end else begin
            r_read_data <= w_rd_byte;
            if (w_chsel_wr && (write_data < 8'(pCHANNELS))) r_ch_sel <= write_data[3:0];
            r_udf <= (r_udf && !w_flush) || w_udf_set;
            r_ovf <= (w_flush ? '0 : r_ovf) | I_fifo_overflow;
            if (w_cnt_clr) begin
                r_pop_cnt <= '0;
            end else if ((w_consume || w_drop) && !(&r_pop_cnt)) begin
                r_pop_cnt <= r_pop_cnt + 1'b1;
            end
        end
    end

    assign read_data = r_read_data;

endmodule
